// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types and defaults for the execute-stage issue controller.
package ex_issue_ctrl_pkg;

    localparam int unsigned EX_PW   = 128;
    localparam int unsigned EX_LATW = 3;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_DRAIN = 2'b01,
        MODE_ACK   = 2'b10
    } ex_mode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } ex_occ_e;

    function automatic ex_occ_e occ_step(input ex_occ_e occ, input logic acc, input logic ret);
        ex_occ_e nxt;
        nxt = occ;
        case (occ)
            OCC_EMPTY: if (acc) nxt = OCC_ONE;
            OCC_ONE: begin
                if (acc && !ret)      nxt = OCC_TWO;
                else if (!acc && ret) nxt = OCC_EMPTY;
            end
            OCC_TWO:   if (ret) nxt = OCC_ONE;
            default:   nxt = OCC_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Upstream/downstream handshake bundle of the issue controller.
interface ex_issue_ctrl_if
    import ex_issue_ctrl_pkg::*;
#(
    parameter int unsigned PW   = EX_PW,
    parameter int unsigned LATW = EX_LATW
) ();

    logic            in_valid;
    logic [PW-1:0]   in_payload;
    logic [LATW-1:0] in_lat;
    logic            stall_up;
    logic            ex_valid;
    logic [PW-1:0]   ex_payload;
    logic            ex_busy;
    logic            down_stall;
    logic            br_flush;
    logic            int_req;
    logic            int_ack;

    modport master (
        output in_valid, in_payload, in_lat, down_stall, br_flush, int_req,
        input  stall_up, ex_valid, ex_payload, ex_busy, int_ack
    );

    modport slave (
        input  in_valid, in_payload, in_lat, down_stall, br_flush, int_req,
        output stall_up, ex_valid, ex_payload, ex_busy, int_ack
    );

endinterface

// File: rtl/ex_skid_slot.sv
// One skid-buffer entry: W-bit register with valid, load, clear and async active-low reset.
module ex_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end
    end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue/flow controller: 2-entry skid buffer in front of execute, multi-cycle hold,
// branch flush and interrupt drain/acknowledge.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int unsigned PW   = EX_PW,
    parameter int unsigned LATW = EX_LATW
) (
    input  logic          clk,
    input  logic          rst,
    ex_issue_ctrl_if.slave io
);

    localparam int unsigned SW = PW + LATW;

    ex_mode_e        mode_q, mode_d;
    ex_occ_e         occ_q, occ_d;
    logic [LATW-1:0] lat_cnt_q, lat_cnt_d;
    logic            stall_q, stall_d;

    logic            head_valid, s1_valid;
    logic [PW-1:0]   head_q, head_d;
    logic [SW-1:0]   s1_q;
    logic            head_load, head_clear, s1_load, s1_clear;
    logic            accept, retire;

    assign accept = io.in_valid & ~stall_q;
    assign retire = io.ex_valid & ~io.down_stall;

    assign io.ex_valid   = head_valid & (lat_cnt_q == '0);
    assign io.ex_busy    = head_valid & (lat_cnt_q != '0);
    assign io.ex_payload = head_q;
    assign io.stall_up   = stall_q;
    assign io.int_ack    = (mode_q == MODE_ACK);

    // Head holds payload only; its latency lives in lat_cnt. Slot1 keeps its latency alongside.
    ex_skid_slot #(.W(PW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .q     (head_q),
        .valid (head_valid)
    );

    ex_skid_slot #(.W(SW)) u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .load  (s1_load),
        .clear (s1_clear),
        .d     ({io.in_payload, io.in_lat}),
        .q     (s1_q),
        .valid (s1_valid)
    );

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        s1_load    = 1'b0;
        s1_clear   = 1'b0;
        head_d     = io.in_payload;
        lat_cnt_d  = lat_cnt_q;
        if (io.br_flush) begin
            head_clear = 1'b1;
            s1_clear   = 1'b1;
            lat_cnt_d  = '0;
        end else begin
            if (retire && s1_valid) begin
                head_load = 1'b1;
                head_d    = s1_q[SW-1:LATW];
                s1_clear  = 1'b1;
                lat_cnt_d = s1_q[LATW-1:0];
            end else if (accept && (retire || !head_valid)) begin
                head_load = 1'b1;
                lat_cnt_d = io.in_lat;
            end else begin
                if (accept)
                    s1_load = 1'b1;
                else if (retire)
                    head_clear = 1'b1;
                if (head_valid && lat_cnt_q != '0)
                    lat_cnt_d = lat_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        occ_d  = io.br_flush ? OCC_EMPTY : occ_step(occ_q, accept, retire);
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:   if (io.int_req) mode_d = MODE_DRAIN;
            MODE_DRAIN: if (occ_d == OCC_EMPTY) mode_d = MODE_ACK;
            MODE_ACK:   mode_d = MODE_RUN;
            default:    mode_d = MODE_RUN;
        endcase
        stall_d = (occ_d == OCC_TWO) | (mode_d != MODE_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q     <= OCC_EMPTY;
            mode_q    <= MODE_RUN;
            lat_cnt_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            mode_q    <= mode_d;
            lat_cnt_q <= lat_cnt_d;
            stall_q   <= stall_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(occ_q == OCC_TWO && accept));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(occ_q == OCC_EMPTY && retire));
    a_occ_matches_slots: assert property (@(posedge clk) disable iff (!rst)
        (occ_q == OCC_EMPTY) == (!head_valid && !s1_valid) &&
        (occ_q == OCC_ONE)   == ( head_valid && !s1_valid) &&
        (occ_q == OCC_TWO)   == ( head_valid &&  s1_valid));

endmodule
